seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller that shares one BCD-to-7-segment decoder across DIGITS common-enable display digits.
- Drives a 4-bit BCD code into the shared decoder and a one-hot digit select to the display.
- Inserts a blanking gap before each digit to suppress ghosting.
- New display values are accepted only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
- DIGITS, 4: number of digits scanned; must be >= 2.
- PRESCALE, 50000: clock cycles per digit slot (blank plus show); must be > BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles per slot with all selects off; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  scan enable; 0 blanks the display and parks the scanner.
- value  input  4*DIGITS  new display value; nibble i = digit i; digit 0 = least significant.
- load  input  1  single-cycle strobe; captures value into the pending register.
- pending  output  1  a captured value is waiting for the next frame boundary.
- bcd  output  4  code to the shared decoder (A=bcd[3] .. D=bcd[0]).
- sel  output  DIGITS  one-hot digit select, active high; all-zero while blanking.
- frame_done  output  1  one-cycle pulse at each completed frame.

Behaviour:
- Reset (async, rst_n=0) clears everything:
  - Outputs: bcd=0, sel=0, pending=0, frame_done=0.
  - Registers: active value=0, pending value=0, index=0, slot counter=0, state=IDLE.
- All outputs are registered.
- Slot counter width is $clog2(PRESCALE).
- Index wraps from DIGITS-1 to 0.
- State machine:
  - IDLE: sel=0, counter=0, index=0. If en=1, go to BLANK next cycle; this transition is a frame boundary.
  - BLANK: sel=0, bcd=active nibble[index]. Counter runs 0..BLANK_CYCLES-1, then go to SHOW with counter cleared.
  - SHOW: sel[index]=1, bcd unchanged. Counter runs 0..PRESCALE-BLANK_CYCLES-1, then:
    - if index < DIGITS-1: index+1, go to BLANK.
    - if index = DIGITS-1: index=0, go to BLANK; this is a frame boundary.
  - en=0 in any state: go to IDLE next cycle (sel=0 on that edge). The active and pending values are retained.
- Slot and frame timing:
  - Slot = exactly PRESCALE cycles: BLANK_CYCLES cycles with sel=0, then PRESCALE-BLANK_CYCLES cycles with sel one-hot.
  - Frame = DIGITS*PRESCALE cycles.
- Frame boundary:
  - If pending=1: active <= pending value and pending <= 0, in the same edge that enters BLANK for digit 0.
  - frame_done is high for exactly the one cycle following each SHOW(DIGITS-1) -> BLANK(0) transition.
  - frame_done is not asserted on the IDLE -> BLANK entry.
- Load rules:
  - load=1 captures value into the pending register and sets pending=1 on the next edge, in any state including IDLE.
  - A second load before the boundary overwrites: last value wins.
  - load on the same edge as a boundary: the boundary consumes the old pending value. The new value is captured and pending stays 1.
- Nibbles > 9 are passed to bcd unchanged; no validation.
- sel is never asserted for more than one digit, and is never asserted during BLANK or IDLE.
- Reset during SHOW: sel drops immediately (asynchronous).

Optional Feature:
- Macro: SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined: for each digit i > 0, if active nibbles i..DIGITS-1 are all zero, sel[i] stays 0 during that digit's SHOW. Slot timing is unchanged. Digit 0 is always shown.
- Undefined: every digit is shown in SHOW regardless of value.

Test Plan (DIGITS=4, PRESCALE=8, BLANK_CYCLES=2):
- Reset, en=1, load value=16'h1234 at cycle 1:
  - pending=1 next cycle; value applied at the first frame boundary.
  - Second frame: sel=0001 with bcd=4 for cycles 2-7 of slot 0, then 0010/3, 0100/2, 1000/1.
  - frame_done period = 32 cycles.
- Load 16'h1111 then 16'h5678 within one frame:
  - Next frame shows 5678.
  - 1111 never appears.
  - pending clears at the boundary.
- Load strobed on the exact boundary edge: old pending value becomes active; the new value shows one frame later; pending=1 throughout.
- Drop en mid-SHOW of digit 2:
  - sel=0 on the next cycle; state IDLE.
  - On en=1, scan restarts at digit 0 after a 2-cycle blank, with no frame_done pulse.
- Assert rst_n=0 mid-frame with active=16'h9876 and pending set: sel, bcd and pending are 0 immediately; after release, with no new load, all digits show 0.
- SEG_SCAN_LZB_EN defined, value=16'h0042: sel[3] and sel[2] never assert; digits 1 and 0 show 4 and 2. With value=16'h0000, only sel[0] asserts.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl
// Time-multiplexed scan controller that shares one BCD-to-7-segment decoder
// across DIGITS common-enable digits. Each digit slot is PRESCALE cycles long:
// BLANK_CYCLES cycles with every select off (anti-ghosting gap), then the
// remaining cycles with the digit's select high. New values are taken only at
// frame boundaries so a frame never mixes old and new digits.
//
// Optional feature (macro SEG_SCAN_LZB_EN): leading-zero blanking. When
// defined, digit i > 0 keeps its select low during SHOW if active nibbles
// i..DIGITS-1 are all zero. Slot timing is unchanged; digit 0 always shows.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   en           in   scan enable; 0 parks the scanner in IDLE with sel=0
//   value        in   4*DIGITS new display value, nibble i = digit i
//   load         in   single-cycle strobe, captures value into pending
//   pending      out  a captured value waits for the next frame boundary
//   bcd          out  4-bit code to the shared decoder
//   sel          out  DIGITS one-hot digit select, all-zero while blanking
//   frame_done   out  one-cycle pulse after each completed frame
//   dbg_state_o  out  FSM state (0=IDLE, 1=BLANK, 2=SHOW)
//
// Handshake: load is a plain strobe with no back-pressure. Every cycle with
// load=1 is accepted; the last strobe before a boundary wins.

`timescale 1ns/1ps

module seg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  output logic                  pending,
  output logic [3:0]            bcd,
  output logic [DIGITS-1:0]     sel,
  output logic                  frame_done,
  output logic [1:0]            dbg_state_o
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(DIGITS);

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [IW-1:0]       idx_q;
  logic [4*DIGITS-1:0] active_q;
  logic [4*DIGITS-1:0] pend_val_q;
  logic                pending_q;
  logic                frame_done_q;
  logic [3:0]          bcd_q;
  logic [DIGITS-1:0]   sel_q;

  // Value that becomes active at a frame boundary: the pending one if any.
  logic [4*DIGITS-1:0] frame_active_d;
  logic [IW-1:0]       idx_inc_d;
  logic [3:0]          nib_inc_d;
  logic [DIGITS-1:0]   sel_cur_d;
  logic [DIGITS-1:0]   show_mask;

  always_comb begin
    frame_active_d = pending_q ? pend_val_q : active_q;
    idx_inc_d      = idx_q + IW'(1);
    nib_inc_d      = active_q[{idx_inc_d, 2'b00} +: 4];
    sel_cur_d      = DIGITS'(1) << idx_q;
  end

`ifdef SEG_SCAN_LZB_EN
  // Scan from the most significant digit down; a digit is shown once any
  // nibble at or above it is non-zero.
  logic seen_nz;
  always_comb begin
    seen_nz      = 1'b0;
    show_mask    = '0;
    show_mask[0] = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      seen_nz      = seen_nz | (active_q[4*i +: 4] != 4'd0);
      show_mask[i] = seen_nz;
    end
  end
`else
  assign show_mask = '1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      pend_val_q   <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      bcd_q        <= 4'd0;
      sel_q        <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (!en) begin
        // Park; active and pending values are kept.
        state_q <= IDLE;
        cnt_q   <= '0;
        idx_q   <= '0;
        sel_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            // Frame boundary without a frame_done pulse.
            state_q   <= BLANK;
            cnt_q     <= '0;
            idx_q     <= '0;
            sel_q     <= '0;
            active_q  <= frame_active_d;
            pending_q <= 1'b0;
            bcd_q     <= frame_active_d[3:0];
          end
          BLANK: begin
            if (cnt_q == BLANK_LAST) begin
              state_q <= SHOW;
              cnt_q   <= '0;
              sel_q   <= sel_cur_d & show_mask;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          SHOW: begin
            if (cnt_q == SHOW_LAST) begin
              state_q <= BLANK;
              cnt_q   <= '0;
              sel_q   <= '0;
              if (idx_q == IDX_LAST) begin
                idx_q        <= '0;
                active_q     <= frame_active_d;
                pending_q    <= 1'b0;
                bcd_q        <= frame_active_d[3:0];
                frame_done_q <= 1'b1;
              end else begin
                idx_q <= idx_inc_d;
                bcd_q <= nib_inc_d;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
      // Placed last so a load on a boundary edge keeps pending set with the
      // new value while the boundary consumes the old one.
      if (load) begin
        pend_val_q <= value;
        pending_q  <= 1'b1;
      end
    end
  end

  assign pending     = pending_q;
  assign bcd         = bcd_q;
  assign sel         = sel_q;
  assign frame_done  = frame_done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
`timescale 1ns/1ps

module tb_seg_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = DIGITS + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic                en;
  logic [4*DIGITS-1:0] value;
  logic                load;
  logic                pending;
  logic [3:0]          bcd;
  logic [DIGITS-1:0]   sel;
  logic                frame_done;
  logic [1:0]          dbg_state;

  seg_scan_ctrl #(
    .DIGITS      (DIGITS),
    .PRESCALE    (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .value       (value),
    .load        (load),
    .pending     (pending),
    .bcd         (bcd),
    .sel         (sel),
    .frame_done  (frame_done),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Push the expected {sel,bcd} of the first ndig digit slots of a frame.
  task automatic push_frame(input logic [4*DIGITS-1:0] v, input int ndig);
    logic [DIGITS-1:0] oh;
    logic [3:0]        nib;
    logic              shown;
    for (int i = 0; i < ndig; i++) begin
      oh    = DIGITS'(1) << i;
      nib   = v[4*i +: 4];
      shown = 1'b1;
`ifdef SEG_SCAN_LZB_EN
      if (i > 0) shown = ((v >> (4*i)) != '0);
`endif
      if (shown) exp_q.push_back({oh, nib});
    end
  endtask

  // Each rising edge of a digit select is one observed show; compare it.
  logic [DIGITS-1:0] prev_sel = '0;
  always @(negedge clk) begin
    if (sel !== '0 && prev_sel === '0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $error("FAIL unexpected_show: got %0h expected none", {sel, bcd});
      end else begin
        check("show", {sel, bcd}, exp_q.pop_front());
      end
    end
    prev_sel = sel;
  end

  // ---------------- driver helpers ----------------
  task automatic wait_fd(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  int n;

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; value = '0;
    repeat (3) @(negedge clk);
    check("rst_sel", sel, 0);
    check("rst_bcd", bcd, 0);
    check("rst_pending", pending, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_state", dbg_state, 0);

    // Enable and load 1234; first frame shows the reset value 0000.
    rst_n = 1'b1; en = 1'b1; load = 1'b1; value = 16'h1234;
    push_frame(16'h0000, 4);
    push_frame(16'h1234, 4);
    @(negedge clk); load = 1'b0;
    check("load_pending", pending, 1);
    check("first_blank_sel", sel, 0);
    check("no_fd_on_entry", frame_done, 0);
    check("state_blank", dbg_state, 1);
    wait_fd(n);
    check("first_frame_len", n, 32);
    check("pending_cleared", pending, 0);
    check("bcd_digit0", bcd, 4);
    check("boundary_sel", sel, 0);
    @(negedge clk);
    check("fd_one_cycle", frame_done, 0);
    check("blank_cycle1_sel", sel, 0);
    @(negedge clk);
    check("show_cycle2_sel", sel, 4'b0001);
    check("show_cycle2_bcd", bcd, 4);

    // Two loads within one frame: last one wins.
    load = 1'b1; value = 16'h1111;
    push_frame(16'h5678, 4);
    @(negedge clk);
    check("overwrite_pending1", pending, 1);
    value = 16'h5678;
    @(negedge clk); load = 1'b0;
    check("overwrite_pending2", pending, 1);
    wait_fd(n);
    check("frame_period", n, 28);
    check("overwrite_cleared", pending, 0);
    check("overwrite_bcd", bcd, 8);

    // Load on the exact boundary edge.
    load = 1'b1; value = 16'h2468;
    push_frame(16'h2468, 4);
    @(negedge clk); load = 1'b0;
    check("edge_pending_a", pending, 1);
    repeat (30) @(negedge clk);
    load = 1'b1; value = 16'h1A3F;
    push_frame(16'h1A3F, 3);
    @(negedge clk); load = 1'b0;
    check("edge_frame_done", frame_done, 1);
    check("edge_pending_kept", pending, 1);
    check("edge_old_value_bcd", bcd, 8);
    repeat (16) @(negedge clk);
    check("edge_pending_mid", pending, 1);
    wait_fd(n);
    check("edge_period", n, 16);
    check("edge_pending_clr", pending, 0);
    check("edge_new_bcd_hex", bcd, 4'hF);

    // Drop en mid-SHOW of digit 2.
    repeat (19) @(negedge clk);
    check("d2_sel", sel, 4'b0100);
    check("d2_bcd_hex", bcd, 4'hA);
    en = 1'b0;
    @(negedge clk);
    check("en_off_sel", sel, 0);
    check("en_off_state", dbg_state, 0);
    repeat (3) @(negedge clk);
    check("idle_sel", sel, 0);
    check("idle_fd", frame_done, 0);
    push_frame(16'h1A3F, 4);
    en = 1'b1;
    @(negedge clk);
    check("restart_no_fd", frame_done, 0);
    check("restart_blank_sel", sel, 0);
    check("restart_bcd", bcd, 4'hF);
    @(negedge clk);
    check("restart_blank2_sel", sel, 0);
    @(negedge clk);
    check("restart_show_sel", sel, 4'b0001);
    wait_fd(n);
    check("restart_frame_len", n, 30);

    // Reset mid-frame with active 9876 and a value pending.
    push_frame(16'h1A3F, 4);
    load = 1'b1; value = 16'h9876;
    push_frame(16'h9876, 1);
    @(negedge clk); load = 1'b0;
    check("r_pending_a", pending, 1);
    wait_fd(n);
    check("r_frame_len", n, 31);
    check("r_active_bcd", bcd, 6);
    load = 1'b1; value = 16'h4321;
    @(negedge clk); load = 1'b0;
    check("r_pending_b", pending, 1);
    repeat (2) @(negedge clk);
    check("r_show_sel", sel, 4'b0001);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_sel", sel, 0);
    check("async_rst_bcd", bcd, 0);
    check("async_rst_pending", pending, 0);
    repeat (2) @(negedge clk);
    push_frame(16'h0000, 4);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_pending", pending, 0);
    check("post_rst_fd", frame_done, 0);
    wait_fd(n);
    check("post_rst_frame_len", n, 32);
    check("post_rst_bcd", bcd, 0);
    en = 1'b0;
    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
